fetch_unit: RTL and testbench

Instruction-fetch initiator for the ROM: drives the ROM program-counter address and `oeb` strobe, captures the returned 16-bit instruction, and hands it to decode over a valid/ready handshake. Sits between the program counter/branch logic and the decode stage, and owns all ROM read sequencing.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc.sv | 25 ++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the ROM instruction-fetch block.
// Optional fetch counter width applies when FETCH_COUNT_EN is defined.
package fetch_pkg;
   localparam int AWIDTH_DEF  = 3;
   localparam int DWIDTH_DEF  = 16;
   localparam int FETCH_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      STROBE  = 3'd2,
      CAPTURE = 3'd3,
      VALID   = 3'd4
   } fetch_state_t;
endpackage

// File: rtl/fetch_pc.sv
// Program-counter register: branch load wins over the wrap-around increment.
module fetch_pc
   import fetch_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              incr,
   input  logic              load,
   input  logic [AWIDTH-1:0] target,
   output logic [AWIDTH-1:0] pc
);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pc <= '0;
      end else if (load) begin
         pc <= target;
      end else if (incr) begin
         pc <= pc + AWIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// ROM fetch sequencer: ADDR -> STROBE (oeb high) -> CAPTURE -> VALID, valid/ready to decode.
// Define FETCH_COUNT_EN to add the saturating fetch_count output.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rstb,
   output logic [AWIDTH-1:0] pc,
   output logic              oeb,
   input  logic [DWIDTH-1:0] rom_inst,
   output logic [DWIDTH-1:0] inst,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              branch_en,
   input  logic [AWIDTH-1:0] branch_target,
   input  logic              halt
`ifdef FETCH_COUNT_EN
   ,
   output logic [FETCH_CNT_W-1:0] fetch_count
`endif
);

   // Handshake: decode takes inst on any rising edge where inst_valid and inst_ready are both 1;
   // inst_valid stays high and inst stays unchanged until that edge (or a branch/reset drops them).
   fetch_state_t state;
   fetch_state_t next_state;
   logic         handshake;

   assign handshake = inst_valid && inst_ready;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = halt ? IDLE : ADDR;
         ADDR:    next_state = STROBE;
         STROBE:  next_state = CAPTURE;
         CAPTURE: next_state = VALID;
         VALID: begin
            if (inst_ready) begin
               next_state = halt ? IDLE : ADDR;
            end
         end
         default: next_state = IDLE;
      endcase
      // A redirect abandons whatever read is in progress.
      if (branch_en) begin
         next_state = halt ? IDLE : ADDR;
      end
   end

   // oeb and inst_valid are decoded from the next state so both come straight from flops.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         oeb        <= 1'b0;
         inst_valid <= 1'b0;
         inst       <= '0;
      end else begin
         oeb        <= (next_state == STROBE);
         inst_valid <= (next_state == VALID);
         if ((state == CAPTURE) && !branch_en) begin
            inst <= rom_inst;
         end
      end
   end

   fetch_pc #(
      .AWIDTH(AWIDTH)
   ) u_fetch_pc (
      .clk   (clk),
      .rstb  (rstb),
      .incr  (handshake),
      .load  (branch_en),
      .target(branch_target),
      .pc    (pc)
   );

`ifdef FETCH_COUNT_EN
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         fetch_count <= '0;
      end else if (handshake && (fetch_count != {FETCH_CNT_W{1'b1}})) begin
         fetch_count <= fetch_count + FETCH_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a read-age model.
module tb_fetch_unit;
   localparam int AW = 3;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rstb;
   logic [AW-1:0] pc;
   logic          oeb;
   logic [DW-1:0] rom_inst = '0;
   logic [DW-1:0] inst;
   logic          inst_valid;
   logic          inst_ready;
   logic          branch_en;
   logic [AW-1:0] branch_target;
   logic          halt;
`ifdef FETCH_COUNT_EN
   logic [15:0]   fetch_count;
`endif

   fetch_unit #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .clk          (clk),
      .rstb         (rstb),
      .pc           (pc),
      .oeb          (oeb),
      .rom_inst     (rom_inst),
      .inst         (inst),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .branch_en    (branch_en),
      .branch_target(branch_target),
      .halt         (halt)
`ifdef FETCH_COUNT_EN
      ,
      .fetch_count  (fetch_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // behavioural ROM: latches mem[pc] on the rising edge of oeb
   logic [DW-1:0] mem [8];
   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
   end
   always @(posedge oeb) rom_inst <= mem[pc];

   // scoreboard
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] dlv_q[$];
   logic [DW-1:0] got_log[$];
   int            got_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: a read is an age counter (0 = address, 1 = strobe, 2 = capture)
   int            m_pc;
   int            m_age;
   bit            m_valid;
   logic [DW-1:0] m_inst;
   int            m_count;

   task automatic model_reset();
      m_pc = 0; m_age = -1; m_valid = 0; m_inst = '0; m_count = 0;
      exp_q.delete();
      dlv_q.delete();
   endtask

   task automatic model_edge();
      bit hs;
      hs = m_valid && inst_ready;
      if (hs) begin
         exp_q.push_back(m_inst);
         if (m_count < 65535) m_count++;
      end
      if (branch_en) begin
         m_pc = int'(branch_target); m_valid = 0; m_age = halt ? -1 : 0;
      end else if (hs) begin
         m_pc = (m_pc + 1) % 8; m_valid = 0; m_age = halt ? -1 : 0;
      end else if (m_valid) begin
         m_age = -1;
      end else if (m_age < 0) begin
         m_age = halt ? -1 : 0;
      end else if (m_age == 2) begin
         m_valid = 1; m_inst = 16'hA000 + 16'(m_pc); m_age = -1;
      end else begin
         m_age++;
      end
   endtask

   task automatic compare_outputs();
      check("pc", 32'(pc), 32'(m_pc));
      check("oeb", 32'(oeb), 32'(m_age == 1));
      check("inst_valid", 32'(inst_valid), 32'(m_valid));
      if (m_valid) check("inst", 32'(inst), 32'(m_inst));
`ifdef FETCH_COUNT_EN
      check("fetch_count", 32'(fetch_count), 32'(m_count));
`endif
   endtask

   // driver: inputs already set; one clock, then compare on the falling edge
   task automatic step();
      if (inst_valid && inst_ready) begin
         dlv_q.push_back(inst);
         got_log.push_back(inst);
         got_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      compare_outputs();
      while (dlv_q.size() > 0 && exp_q.size() > 0)
         check("deliver", 32'(dlv_q.pop_front()), 32'(exp_q.pop_front()));
   endtask

   int base;
   bit ok;

   initial begin
      rstb = 1'b0; inst_ready = 1'b1; branch_en = 1'b0; branch_target = '0; halt = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_oeb", 32'(oeb), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", 32'(inst), 32'd0);

      // streaming with ready high: 0..7, one every 4 cycles
      for (int n = 0; n < 100 && got_log.size() < 8; n++) step();
      check("t1_count", 32'(got_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < got_log.size(); i++) begin
         check("t1_inst", 32'(got_log[i]), 32'hA000 + 32'(i));
         if (i > 0) check("t1_period", 32'(got_cyc[i] - got_cyc[i-1]), 32'd4);
      end

      // decode stalls on the wrapped pc 0 fetch
      inst_ready = 1'b0;
      for (int n = 0; n < 10 && !m_valid; n++) step();
      check("t2_reach", 32'(m_valid), 32'd1);
      for (int n = 0; n < 10; n++) begin
         step();
         check("t2_inst", 32'(inst), 32'hA000);
         check("t2_valid", 32'(inst_valid), 32'd1);
         check("t2_pc", 32'(pc), 32'd0);
         check("t2_oeb", 32'(oeb), 32'd0);
      end
      inst_ready = 1'b1;
      step();
      check("t2_deliv", 32'(got_log.size() > 8 ? got_log[8] : 16'h0), 32'hA000);

      // branch to 5 during the strobe of pc 2
      for (int n = 0; n < 40 && !(m_age == 1 && m_pc == 2); n++) step();
      check("t3_reach", 32'(m_age == 1 && m_pc == 2), 32'd1);
      base = got_log.size();
      branch_en = 1'b1; branch_target = 3'd5;
      step();
      branch_en = 1'b0;
      check("t3_pc", 32'(pc), 32'd5);
      for (int n = 0; n < 20 && got_log.size() <= base; n++) step();
      check("t3_next", 32'(got_log.size() > base ? got_log[base] : 16'h0), 32'hA005);

      // branch to 3 in the same cycle as the pc 6 handshake
      for (int n = 0; n < 20 && !(m_valid && m_pc == 6); n++) step();
      check("t4_reach", 32'(m_valid && m_pc == 6), 32'd1);
      base = got_log.size();
      branch_en = 1'b1; branch_target = 3'd3;
      step();
      branch_en = 1'b0;
      check("t4_kept", 32'(got_log.size() > base ? got_log[base] : 16'h0), 32'hA006);
      check("t4_pc", 32'(pc), 32'd3);
      for (int n = 0; n < 20 && got_log.size() <= base + 1; n++) step();
      check("t4_next", 32'(got_log.size() > base + 1 ? got_log[base+1] : 16'h0), 32'hA003);

      // halt raised during capture of pc 4
      for (int n = 0; n < 20 && !(m_age == 2 && m_pc == 4); n++) step();
      check("t5_reach", 32'(m_age == 2 && m_pc == 4), 32'd1);
      halt = 1'b1;
      base = got_log.size();
      for (int n = 0; n < 10 && got_log.size() <= base; n++) step();
      check("t5_deliv", 32'(got_log.size() > base ? got_log[base] : 16'h0), 32'hA004);
      repeat (5) step();
      check("t5_idle_oeb", 32'(oeb), 32'd0);
      check("t5_idle_valid", 32'(inst_valid), 32'd0);
      check("t5_idle_pc", 32'(pc), 32'd5);
      check("t5_no_more", 32'(got_log.size()), 32'(base + 1));
      halt = 1'b0;
      for (int n = 0; n < 20 && got_log.size() <= base + 1; n++) step();
      check("t5_resume", 32'(got_log.size() > base + 1 ? got_log[base+1] : 16'h0), 32'hA005);

      // asynchronous reset in the middle of a strobe
      for (int n = 0; n < 20 && m_age != 1; n++) step();
      check("t6_reach", 32'(m_age), 32'd1);
      rstb = 1'b0;
      #1;
      check("t6_oeb", 32'(oeb), 32'd0);
      check("t6_valid", 32'(inst_valid), 32'd0);
      check("t6_pc", 32'(pc), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rstb = 1'b1;
      check("t6_inst", 32'(inst), 32'd0);
`ifdef FETCH_COUNT_EN
      check("t6_cnt0", 32'(fetch_count), 32'd0);
`endif
      base = got_log.size();
      for (int n = 0; n < 60 && got_log.size() < base + 8; n++) step();
      check("t6_first", 32'(got_log.size() > base ? got_log[base] : 16'h0), 32'hA000);
      check("t6_eighth", 32'(got_log.size() > base + 7 ? got_log[base+7] : 16'h0), 32'hA007);
`ifdef FETCH_COUNT_EN
      step();
      check("t6_cnt8", 32'(fetch_count), 32'd8);
`endif

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         inst_ready    = ($urandom_range(0, 3) != 0);
         branch_en     = ($urandom_range(0, 15) == 0);
         branch_target = AW'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) halt = ~halt;
         step();
      end
      branch_en = 1'b0; halt = 1'b0; inst_ready = 1'b1;
      repeat (8) step();
      ok = (exp_q.size() == dlv_q.size());
      check("sb_drain", 32'(ok), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
